mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequencer and two-port arbiter for the shared 16x16 unsigned registered multiplier cell in the Nios II-side datapath. It accepts 32x32 unsigned multiply requests from two requesters and grants them round-robin. For each granted request it issues the four 16x16 partial products to the cell one per cycle, then accumulates the returning products into a 64-bit result. The result is held with a valid/ready handshake, tagged with the requester ID.

## Interface
Parameters:
- PIPE_LAT, 1: cycles from a cycle with mul_en=1 to that product appearing on mul_p. Legal range 1..3.

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  32 each  requester 0 operands, unsigned
- req1_valid  in  1  requester 1 has an operation pending
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a, req1_b  in  32 each  requester 1 operands, unsigned
- res_valid  out  1  result available
- res_ready  in  1  result consumer accepts
- res_id  out  1  requester that owns the result
- res_data  out  64  full product a*b
- busy  out  1  high in every state except IDLE
- mul_a, mul_b  out  16 each  operands to the multiplier cell
- mul_en  out  1  multiplier cell clock enable; high only on issue cycles
- mul_p  in  32  multiplier cell product

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - Arbitration:
    - Only one valid: that requester is granted.
    - Both valid: the requester not served last is granted.
    - The last-served pointer resets to 1, so req0 wins the first tie.
  - reqN_ready = IDLE & grant==N. It may depend combinationally on reqN_valid.
  - Accept (reqN_valid & reqN_ready):
    - latch a, b and id=N; clear acc to 0; issue counter k=0; go to ISSUE.
- **ISSUE**, 4 cycles, k=0..3:
  - mul_en=1.
  - Operand pairs by k:
    - k=0: aL*bL
    - k=1: aL*bH
    - k=2: aH*bL
    - k=3: aH*bH
  - aL/aH are bits 15:0/31:16.
  - Each issue pushes (valid, k) into a PIPE_LAT-deep tag shift register.
  - After k=3, go to DRAIN.
- **Return path** (ISSUE and DRAIN): when the tag output is valid, acc += mul_p << shift(k).
  - shift(0)=0, shift(1)=shift(2)=16, shift(3)=32.
  - The addition is 64-bit; zero-extend mul_p. No overflow is possible.
- **DRAIN**: when the k=3 product has been accumulated, load res_data=acc, res_id=id, and go to DONE.
- **DONE**
  - res_valid=1; res_data and res_id are held stable until res_ready.
  - On res_ready: update the last-served pointer to id and go to IDLE.
  - No new request is accepted in the same cycle as the result handshake.
- mul_a and mul_b are 0 whenever mul_en=0. The cell holds its register while mul_en=0.
- Operand inputs are sampled only on the accept cycle. Later changes on reqN_a/b have no effect.
- A requester that drops valid before it is accepted is simply not granted; there is no penalty.
- Reset, asynchronous, at any time including mid-ISSUE/DRAIN/DONE:
  - state=IDLE, acc=0, tags cleared, pointer=1.
  - The in-flight operation is discarded and no result is produced.
  - Stale products that arrive after reset deassertion are ignored because their tags were cleared.
- Reset values of outputs: req0_ready=0 and req1_ready=0 (unless reqN_valid is already asserted in IDLE), res_valid=0, res_id=0, res_data=0, busy=0, mul_en=0, mul_a=0, mul_b=0.

## Timing
- Accept at the edge ending cycle 0. Issue cycles are 1..4. Products return in cycles 1+PIPE_LAT..4+PIPE_LAT.
- The final accumulate is at the end of cycle 4+PIPE_LAT, so res_valid is first high in cycle 5+PIPE_LAT (cycle 6 for PIPE_LAT=1).
- busy is high from cycle 1 through the cycle of the result handshake.
- Minimum initiation interval is 6+PIPE_LAT cycles when res_ready is held high: accept, 4 issue cycles, PIPE_LAT drain cycles, 1 DONE cycle.
- mul_en is high for exactly 4 consecutive cycles per operation. It is never high outside ISSUE.

## Test plan
- Single op, PIPE_LAT=1: req0 a=0xFFFFFFFF, b=0xFFFFFFFF, res_ready=1.
  - Expect res_data=0xFFFFFFFE00000001, res_id=0.
  - Expect res_valid high in cycle 6 for exactly 1 cycle; mul_en high in cycles 1-4.
- Simultaneous requests: req0 (a=0x00012345, b=0x00010000) and req1 (a=3, b=5) valid together from reset.
  - Expect req0 served first: 0x0000000123450000, res_id=0.
  - Then req1: 15, res_id=1.
  - Repeat the tie: req0 is served next, which checks the round-robin pointer.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid rises.
  - Expect res_data/res_id stable, both reqN_ready low, mul_en low.
  - One cycle after res_ready, IDLE: a pending request is accepted.
- Reset mid-op: assert reset during ISSUE k=2.
  - Expect all outputs at reset values immediately.
  - After release, a new op a=7, b=6 returns exactly 42, with no corruption from stale products.
- PIPE_LAT=3: a=0x80000000, b=2.
  - Expect res_data=0x0000000100000000 with res_valid first high in cycle 8.
- Zero operands: a=0, b=0xDEADBEEF.
  - Expect res_data=0. Full sequence still runs: mul_en asserted 4 cycles.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: round-robin arbiter and sequencer for a shared 16x16 unsigned
// registered multiplier cell. Each 32x32 request is split into four 16x16
// partial products, issued one per cycle. The returning products are shifted
// into place and summed into a 64-bit result. The result is handed out with a
// valid/ready handshake.
module mul_seq_ctrl #(
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [63:0] res_data,
  output logic        busy,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Each tag-pipe entry is {valid, k}; the oldest entry sits in the top bits.
  localparam int TW = 3 * PIPE_LAT;

  // Place a 32-bit partial product at its weight inside the 64-bit sum.
  function automatic logic [63:0] align_product(input logic [31:0] p, input logic [1:0] k);
    logic [63:0] r;
    case (k)
      2'd0:       r = {32'd0, p};
      2'd1, 2'd2: r = {16'd0, p, 16'd0};
      2'd3:       r = {p, 32'd0};
      default:    r = 64'd0;
    endcase
    return r;
  endfunction

  // Select the low or high half of an operand word.
  function automatic logic [15:0] half_sel(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    k_r, k_nx_s;
  logic [31:0]   a_r, a_nx_s;
  logic [31:0]   b_r, b_nx_s;
  logic          id_r, id_nx_s;
  logic [63:0]   acc_r, acc_nx_s;
  logic          last_r, last_nx_s;
  logic [63:0]   res_data_r, res_data_nx_s;
  logic          res_id_r, res_id_nx_s;
  logic          res_valid_r;
  logic          busy_r;
  logic          mul_en_r;
  logic [15:0]   mul_a_r, mul_b_r;
  logic [15:0]   mul_a_nx_s, mul_b_nx_s;
  logic [TW-1:0] tag_sr_r;
  logic [TW+2:0] tag_ext_s;
  logic [2:0]    tag_new_s;
  logic [2:0]    tag_out_s;
  logic          tag_vld_s;
  logic [1:0]    tag_k_s;
  logic [63:0]   acc_sum_s;
  logic          grant_s;
  logic          accept_s;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else begin
      grant_s = req1_valid;
    end
  end

  assign req0_ready = (state_r == IDLE) && req0_valid && !grant_s;
  assign req1_ready = (state_r == IDLE) && req1_valid && grant_s;
  assign accept_s   = (state_r == IDLE) && (req0_valid || req1_valid);

  // The tag pipe mirrors the cell latency, so tag_out_s describes mul_p.
  assign tag_new_s = {(state_r == ISSUE), k_r};
  assign tag_ext_s = {tag_sr_r, tag_new_s};
  assign tag_out_s = tag_sr_r[TW-1 -: 3];
  assign tag_vld_s = tag_out_s[2];
  assign tag_k_s   = tag_out_s[1:0];
  assign acc_sum_s = acc_r + (tag_vld_s ? align_product(mul_p, tag_k_s) : 64'd0);

  // Next-state and datapath-load decisions for the sequencer.
  always_comb begin
    state_s       = state_r;
    k_nx_s        = k_r;
    a_nx_s        = a_r;
    b_nx_s        = b_r;
    id_nx_s       = id_r;
    acc_nx_s      = acc_r;
    last_nx_s     = last_r;
    res_data_nx_s = res_data_r;
    res_id_nx_s   = res_id_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s  = ISSUE;
          a_nx_s   = grant_s ? req1_a : req0_a;
          b_nx_s   = grant_s ? req1_b : req0_b;
          id_nx_s  = grant_s;
          acc_nx_s = 64'd0;
          k_nx_s   = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        acc_nx_s = acc_sum_s;
        if (k_r == 2'd3) begin
          state_s = DRAIN;
        end else begin
          k_nx_s = k_r + 2'd1;
        end
      end
      DRAIN: begin
        acc_nx_s = acc_sum_s;
        if (tag_vld_s && (tag_k_s == 2'd3)) begin
          state_s       = DONE;
          res_data_nx_s = acc_sum_s;
          res_id_nx_s   = id_r;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_s   = IDLE;
          last_nx_s = id_r;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operands for the next cycle; k[1] picks the a half, k[0] the b half.
  assign mul_a_nx_s = (state_s == ISSUE) ? half_sel(a_nx_s, k_nx_s[1]) : 16'd0;
  assign mul_b_nx_s = (state_s == ISSUE) ? half_sel(b_nx_s, k_nx_s[0]) : 16'd0;

  // State, datapath, tag pipe and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      k_r         <= 2'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      id_r        <= 1'b0;
      acc_r       <= 64'd0;
      last_r      <= 1'b1;
      res_data_r  <= 64'd0;
      res_id_r    <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      mul_en_r    <= 1'b0;
      mul_a_r     <= 16'd0;
      mul_b_r     <= 16'd0;
      tag_sr_r    <= '0;
    end else begin
      state_r     <= state_s;
      k_r         <= k_nx_s;
      a_r         <= a_nx_s;
      b_r         <= b_nx_s;
      id_r        <= id_nx_s;
      acc_r       <= acc_nx_s;
      last_r      <= last_nx_s;
      res_data_r  <= res_data_nx_s;
      res_id_r    <= res_id_nx_s;
      res_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      mul_en_r    <= (state_s == ISSUE);
      mul_a_r     <= mul_a_nx_s;
      mul_b_r     <= mul_b_nx_s;
      tag_sr_r    <= tag_ext_s[TW-1:0];
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign busy      = busy_r;
  assign mul_en    = mul_en_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: one instance with PIPE_LAT=1 and one with
// PIPE_LAT=3, each paired with a behavioural multiplier cell.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        res_ready = 1'b1;
  logic        req0_ready, req1_ready, res_valid, res_id, busy, mul_en;
  logic [63:0] res_data;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p = 32'd0;

  logic        r3_req0_valid = 1'b0;
  logic        r3_req0_ready, r3_req1_ready, r3_res_valid, r3_res_id, r3_busy, r3_mul_en;
  logic [63:0] r3_res_data;
  logic [15:0] r3_mul_a, r3_mul_b;
  logic [31:0] r3_p0 = 32'd0, r3_p1 = 32'd0, r3_mul_p = 32'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.PIPE_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p)
  );

  mul_seq_ctrl #(.PIPE_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(r3_req0_valid), .req0_ready(r3_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(1'b0), .req1_ready(r3_req1_ready), .req1_a(32'd0), .req1_b(32'd0),
    .res_valid(r3_res_valid), .res_ready(1'b1), .res_id(r3_res_id), .res_data(r3_res_data),
    .busy(r3_busy), .mul_a(r3_mul_a), .mul_b(r3_mul_b), .mul_en(r3_mul_en), .mul_p(r3_mul_p)
  );

  // Latency-1 cell: the product register only loads on enable.
  always @(posedge clk) begin
    if (mul_en) mul_p <= 32'(mul_a) * 32'(mul_b);
  end

  // Latency-3 cell: enabled input register followed by two free-running stages.
  always @(posedge clk) begin
    if (r3_mul_en) r3_p0 <= 32'(r3_mul_a) * 32'(r3_mul_b);
    r3_p1    <= r3_p0;
    r3_mul_p <= r3_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk cycles until res_valid, noting when mul_en was high. Cycle numbers
  // count from the accept cycle (0); start is the current cycle number.
  task automatic collect(input bit sel3, input int start, input int budget,
                         output int rv_cyc, output int en_first, output int en_last,
                         output int en_cnt, output logic [63:0] d, output logic id);
    logic rv, en;
    rv_cyc = 0; en_first = 0; en_last = 0; en_cnt = 0; d = 64'd0; id = 1'b0;
    for (int c = start; c < start + budget; c++) begin
      rv = sel3 ? r3_res_valid : res_valid;
      en = sel3 ? r3_mul_en : mul_en;
      if (en) begin
        en_cnt++;
        if (en_first == 0) en_first = c;
        en_last = c;
      end
      if (rv) begin
        rv_cyc = c;
        d  = sel3 ? r3_res_data : res_data;
        id = sel3 ? r3_res_id : res_id;
        break;
      end
      tick();
    end
  endtask

  int          rc, ef, el, ec;
  logic [63:0] d;
  logic        id;

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_en", 64'(mul_en), 64'd0);
    chk("rst_mul_ab", {32'd0, mul_a, mul_b}, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("rst3_res_valid", 64'(r3_res_valid), 64'd0);
    reset = 1'b0;

    // Single op, all-ones operands
    tick();
    req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_valid = 1'b1;
    #1;
    chk("t1_ready", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick();
    req0_valid = 1'b0;
    chk("t1_busy_c1", 64'(busy), 64'd1);
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    chk("t1_rv_cycle", 64'(rc), 64'd6);
    chk("t1_en_window", {16'(ef), 16'(el), 32'(ec)}, {16'd1, 16'd4, 32'd4});
    chk("t1_data", d, 64'hFFFF_FFFE_0000_0001);
    chk("t1_id", 64'(id), 64'd0);
    chk("t1_busy_hs", 64'(busy), 64'd1);
    tick();
    chk("t1_rv_one_cycle", 64'(res_valid), 64'd0);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // Simultaneous requests from reset: req0, req1, req0
    reset = 1'b1; tick(); reset = 1'b0;
    req0_a = 32'h0001_2345; req0_b = 32'h0001_0000; req0_valid = 1'b1;
    req1_a = 32'd3;         req1_b = 32'd5;         req1_valid = 1'b1;
    #1;
    chk("t2_ready_first", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick();
    chk("t2_ops_k0", {32'd0, mul_a, mul_b}, {32'd0, 16'h2345, 16'h0000});
    tick();
    chk("t2_ops_k1", {32'd0, mul_a, mul_b}, {32'd0, 16'h2345, 16'h0001});
    tick();
    chk("t2_ops_k2", {32'd0, mul_a, mul_b}, {32'd0, 16'h0001, 16'h0000});
    tick();
    chk("t2_ops_k3", {32'd0, mul_a, mul_b}, {32'd0, 16'h0001, 16'h0001});
    collect(1'b0, 4, 20, rc, ef, el, ec, d, id);
    chk("t2a_rv_cycle", 64'(rc), 64'd6);
    chk("t2a_data", d, 64'h0000_0001_2345_0000);
    chk("t2a_id", 64'(id), 64'd0);
    tick();
    chk("t2_ready_second", {62'd0, req0_ready, req1_ready}, 64'd1);
    tick();
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    chk("t2b_data", d, 64'd15);
    chk("t2b_id", 64'(id), 64'd1);
    tick();
    chk("t2_ready_third", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick();
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2c_data", d, 64'h0000_0001_2345_0000);
    chk("t2c_id", 64'(id), 64'd0);
    tick();

    // Backpressure: result held, nothing accepted, cell idle
    res_ready = 1'b0;
    req0_a = 32'h0000_FFFF; req0_b = 32'h0001_0001; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    chk("t3_rv_cycle", 64'(rc), 64'd6);
    chk("t3_data", d, 64'h0000_0000_FFFF_FFFF);
    req1_a = 32'd3; req1_b = 32'd5; req1_valid = 1'b1;
    #1;
    chk("t3_ready_hold_c6", {62'd0, req0_ready, req1_ready}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 64'(res_valid), 64'd1);
      chk("t3_hold_data", res_data, 64'h0000_0000_FFFF_FFFF);
      chk("t3_hold_id", 64'(res_id), 64'd0);
      chk("t3_hold_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      chk("t3_hold_en_busy", {62'd0, mul_en, busy}, 64'd1);
    end
    res_ready = 1'b1;
    tick();
    chk("t3_idle_accept", {62'd0, req0_ready, req1_ready}, 64'd1);
    tick();
    req1_valid = 1'b0;
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    chk("t3b_rv_cycle", 64'(rc), 64'd6);
    chk("t3b_data", d, 64'd15);
    chk("t3b_id", 64'(id), 64'd1);
    tick();

    // Reset during ISSUE k=2, then a clean op
    req0_a = 32'h1234_5678; req0_b = 32'h9ABC_DEF0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    chk("t4_issue_k2", {32'd0, mul_a, mul_b}, {32'd0, 16'h1234, 16'hDEF0});
    reset = 1'b1;
    #1;
    chk("t4_rst_outs", {59'd0, res_valid, busy, mul_en, res_id, req0_ready}, 64'd0);
    chk("t4_rst_mul_ab", {32'd0, mul_a, mul_b}, 64'd0);
    chk("t4_rst_data", res_data, 64'd0);
    tick();
    reset = 1'b0;
    req0_a = 32'd7; req0_b = 32'd6; req0_valid = 1'b1;
    #1;
    chk("t4_ready", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick();
    req0_valid = 1'b0;
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    chk("t4_rv_cycle", 64'(rc), 64'd6);
    chk("t4_data", d, 64'd42);
    tick();

    // Zero operand: full sequence still runs
    req0_a = 32'd0; req0_b = 32'hDEAD_BEEF; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    collect(1'b0, 1, 20, rc, ef, el, ec, d, id);
    chk("t5_en_window", {16'(ef), 16'(el), 32'(ec)}, {16'd1, 16'd4, 32'd4});
    chk("t5_data", d, 64'd0);
    chk("t5_rv_cycle", 64'(rc), 64'd6);
    tick();

    // PIPE_LAT=3 instance
    req0_a = 32'h8000_0000; req0_b = 32'd2; r3_req0_valid = 1'b1;
    #1;
    chk("t6_ready", {62'd0, r3_req0_ready, r3_req1_ready}, 64'd2);
    tick();
    r3_req0_valid = 1'b0;
    collect(1'b1, 1, 20, rc, ef, el, ec, d, id);
    chk("t6_rv_cycle", 64'(rc), 64'd8);
    chk("t6_en_window", {16'(ef), 16'(el), 32'(ec)}, {16'd1, 16'd4, 32'd4});
    chk("t6_data", d, 64'h0000_0001_0000_0000);
    chk("t6_id", 64'(id), 64'd0);
    tick();
    chk("t6_rv_one_cycle", 64'(r3_res_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
